// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the pipeline and the branch predictor.
// The pipeline drives the master modport and the predictor takes the slave modport.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output if_pc,
    output ex_valid, ex_is_br, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_count, mispred_count
  );

  modport slave (
    input  if_pc,
    input  ex_valid, ex_is_br, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter BHT plus tagged BTB sharing one index, with combinational
// IF-side lookup, EX-side training, mispredict/redirect generation and statistics counters.
module branch_predictor #(
  parameter int         INDEX_BITS = 5,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [31:0]        r_br_count;
  logic [31:0]        r_mispred_count;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_hit;
  logic                  w_pred_taken;
  logic [31:0]           w_if_pc_plus4;

  logic                  w_ex_upd;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_dir_wrong;
  logic                  w_tgt_wrong;
  logic                  w_mispredict;
  logic [31:0]           w_ex_pc_plus4;
  logic                  w_unused_lsbs;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       nxt = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    return nxt;
  endfunction

  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] cnt, input logic en);
    return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

  assign w_unused_lsbs = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

  // IF-side lookup reads registered table state only, so same-cycle updates are not bypassed
  always_comb begin
    w_if_idx      = bp.if_pc[INDEX_BITS+1:2];
    w_if_tag      = bp.if_pc[31:INDEX_BITS+2];
    w_if_pc_plus4 = bp.if_pc + 32'd4;
    w_hit         = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    w_pred_taken  = w_hit && r_ctr[w_if_idx][1];
  end

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : w_if_pc_plus4;

  // EX-side resolution against what was predicted when this instruction was fetched
  always_comb begin
    w_ex_upd      = bp.ex_valid && bp.ex_is_br;
    w_ex_idx      = bp.ex_pc[INDEX_BITS+1:2];
    w_ex_tag      = bp.ex_pc[31:INDEX_BITS+2];
    w_ex_pc_plus4 = bp.ex_pc + 32'd4;
    w_dir_wrong   = bp.ex_taken != bp.ex_pred_taken;
    w_tgt_wrong   = bp.ex_taken && (bp.ex_pred_target != bp.ex_target);
    w_mispredict  = w_ex_upd && (w_dir_wrong || w_tgt_wrong);
  end

  assign bp.mispredict    = w_mispredict;
  assign bp.redirect_pc   = bp.ex_taken ? bp.ex_target : w_ex_pc_plus4;
  assign bp.br_count      = r_br_count;
  assign bp.mispred_count = r_mispred_count;

  // Counters train on index alone; a taken branch claims the BTB entry even if aliased
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= '0;
      r_br_count      <= '0;
      r_mispred_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (w_ex_upd) begin
      r_ctr[w_ex_idx] <= ctr_next(r_ctr[w_ex_idx], bp.ex_taken);
      if (bp.ex_taken) begin
        r_valid[w_ex_idx] <= 1'b1;
      end
      r_br_count      <= cnt_sat_inc(r_br_count, 1'b1);
      r_mispred_count <= cnt_sat_inc(r_mispred_count, w_mispredict);
    end
  end

  // Tag/target payload is qualified by r_valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_ex_upd && bp.ex_taken) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= bp.ex_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: one task per scenario with hand-computed
// expectations for lookup, training, aliasing, target mispredicts, wrap and async reset.
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  branch_predictor_if bp();

  branch_predictor #(.INDEX_BITS(5), .CTR_INIT(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_ex(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bp.ex_valid = v; bp.ex_is_br = br; bp.ex_pc = pc; bp.ex_taken = tk;
    bp.ex_target = tgt; bp.ex_pred_taken = ptk; bp.ex_pred_target = ptgt;
  endtask

  task automatic clr_ex();
    set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clr_ex();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bp.if_pc = 32'h100;
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken: got %b want 0", bp.pred_taken); end
    tests++; if (bp.pred_target !== 32'h104) begin fails++; $display("FAIL reset_pred_target: got %h want 00000104", bp.pred_target); end
    tests++; if (bp.br_count !== 32'd0) begin fails++; $display("FAIL reset_br_count: got %0d want 0", bp.br_count); end
    tests++; if (bp.mispred_count !== 32'd0) begin fails++; $display("FAIL reset_mispred_count: got %0d want 0", bp.mispred_count); end
    tests++; if (bp.mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict: got %b want 0", bp.mispredict); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_update();
    apply_reset();
    bp.if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    tests++; if (bp.mispredict !== 1'b1) begin fails++; $display("FAIL first_mispredict: got %b want 1", bp.mispredict); end
    tests++; if (bp.redirect_pc !== 32'h80) begin fails++; $display("FAIL first_redirect: got %h want 00000080", bp.redirect_pc); end
    tests++; if (bp.pred_taken !== 1'b0) begin fails++; $display("FAIL first_same_cycle: got %b want 0", bp.pred_taken); end
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b1) begin fails++; $display("FAIL first_next_taken: got %b want 1", bp.pred_taken); end
    tests++; if (bp.pred_target !== 32'h80) begin fails++; $display("FAIL first_next_target: got %h want 00000080", bp.pred_target); end
    tests++; if (bp.br_count !== 32'd1 || bp.mispred_count !== 32'd1) begin fails++; $display("FAIL first_counts: got %0d/%0d want 1/1", bp.br_count, bp.mispred_count); end
    bp.if_pc = 32'h104;
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h108) begin fails++; $display("FAIL first_other_index: got %b/%h want 0/00000108", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_training();
    apply_reset();
    bp.if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      tests++; if (bp.mispredict !== 1'b0) begin fails++; $display("FAIL train_correct_%0d: got %b want 0", i, bp.mispredict); end
      tick();
    end
    set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    tests++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h104) begin fails++; $display("FAIL train_nt1_mispredict: got %b/%h want 1/00000104", bp.mispredict, bp.redirect_pc); end
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b1) begin fails++; $display("FAIL train_nt1_still_taken: got %b want 1", bp.pred_taken); end
    // non-branch and invalid EX slots must neither flag nor count
    set_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    tests++; if (bp.mispredict !== 1'b0) begin fails++; $display("FAIL nonbranch_mispredict: got %b want 0", bp.mispredict); end
    tick();
    set_ex(1'b0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    tests++; if (bp.mispredict !== 1'b0) begin fails++; $display("FAIL invalid_mispredict: got %b want 0", bp.mispredict); end
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b1) begin fails++; $display("FAIL nonbranch_no_train: got %b want 1", bp.pred_taken); end
    set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin fails++; $display("FAIL train_nt2: got %b/%h want 0/00000104", bp.pred_taken, bp.pred_target); end
    tests++; if (bp.br_count !== 32'd6) begin fails++; $display("FAIL train_br_count: got %0d want 6", bp.br_count); end
    tests++; if (bp.mispred_count !== 32'd3) begin fails++; $display("FAIL train_mispred_count: got %0d want 3", bp.mispred_count); end
  endtask

  task automatic test_alias();
    apply_reset();
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    clr_ex();
    bp.if_pc = 32'h180;
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h184) begin fails++; $display("FAIL alias_miss: got %b/%h want 0/00000184", bp.pred_taken, bp.pred_target); end
    set_ex(1'b1, 1'b1, 32'h180, 1'b1, 32'h40, 1'b0, 32'h184);
    #1;
    tests++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h40) begin fails++; $display("FAIL alias_mispredict: got %b/%h want 1/00000040", bp.mispredict, bp.redirect_pc); end
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h40) begin fails++; $display("FAIL alias_new_owner: got %b/%h want 1/00000040", bp.pred_taken, bp.pred_target); end
    bp.if_pc = 32'h100;
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin fails++; $display("FAIL alias_evicted: got %b/%h want 0/00000104", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_target_mispredict();
    apply_reset();
    bp.if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    #1;
    tests++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h90) begin fails++; $display("FAIL tgt_mispredict: got %b/%h want 1/00000090", bp.mispredict, bp.redirect_pc); end
    tests++; if (bp.pred_target !== 32'h80) begin fails++; $display("FAIL tgt_same_cycle: got %h want 00000080", bp.pred_target); end
    tick();
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90);
    #1;
    tests++; if (bp.pred_target !== 32'h90) begin fails++; $display("FAIL tgt_next_cycle: got %h want 00000090", bp.pred_target); end
    tests++; if (bp.mispredict !== 1'b0) begin fails++; $display("FAIL tgt_correct: got %b want 0", bp.mispredict); end
    tick();
    clr_ex();
    #1;
    tests++; if (bp.br_count !== 32'd3 || bp.mispred_count !== 32'd2) begin fails++; $display("FAIL tgt_counts: got %0d/%0d want 3/2", bp.br_count, bp.mispred_count); end
  endtask

  task automatic test_wrap_and_floor();
    apply_reset();
    bp.if_pc = 32'hFFFF_FFFC;
    #1;
    tests++; if (bp.pred_target !== 32'h0) begin fails++; $display("FAIL wrap_pred_target: got %h want 00000000", bp.pred_target); end
    set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    tests++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h0) begin fails++; $display("FAIL wrap_redirect: got %b/%h want 1/00000000", bp.mispredict, bp.redirect_pc); end
    tick();
    set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h200, 1'b0, 32'h0);
    tick();
    // counter floored at 00, so one taken lands on 01 (still not taken)
    set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h0) begin fails++; $display("FAIL floor_saturate: got %b/%h want 0/00000000", bp.pred_taken, bp.pred_target); end
    set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    clr_ex();
    #1;
    tests++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h200) begin fails++; $display("FAIL floor_recover: got %b/%h want 1/00000200", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bp.if_pc = 32'h100;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    tick();
    tick();
    #2;
    set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    rst_n = 1'b0;
    #1;
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin fails++; $display("FAIL async_pred: got %b/%h want 0/00000104", bp.pred_taken, bp.pred_target); end
    tests++; if (bp.br_count !== 32'd0 || bp.mispred_count !== 32'd0) begin fails++; $display("FAIL async_counts: got %0d/%0d want 0/0", bp.br_count, bp.mispred_count); end
    tests++; if (bp.mispredict !== 1'b1) begin fails++; $display("FAIL async_mispredict_comb: got %b want 1", bp.mispredict); end
    tick();
    tests++; if (bp.br_count !== 32'd0) begin fails++; $display("FAIL async_held: got %0d want 0", bp.br_count); end
    @(negedge clk);
    clr_ex();
    rst_n = 1'b1;
    tick();
    tests++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h104) begin fails++; $display("FAIL async_no_stale: got %b/%h want 0/00000104", bp.pred_taken, bp.pred_target); end
    tests++; if (bp.br_count !== 32'd0) begin fails++; $display("FAIL async_after_release: got %0d want 0", bp.br_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_update();
    test_training();
    test_alias();
    test_target_mispredict();
    test_wrap_and_floor();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
